// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl
//   Produces the one-cycle clock-enable strobe that advances the pipelined
//   CPU. Free-run mode emits a strobe every 2^N clk cycles (N selected by
//   SW2). Step mode emits one strobe per debounced button press. A halt
//   request from the CPU parks the controller until run_sw is cycled low.
//
//   Optional feature macro: STEP_CNT_EN
//     defined   : step_cnt counts issued cpu_en pulses (wraps at 2^32)
//     undefined : no counter is built, step_cnt is tied to zero
//
// Ports
//   clk       in   board clock, rising edge
//   rst       in   asynchronous active-high reset
//   SW2       in   async rate select (1 = slow, 0 = fast)
//   run_sw    in   async mode select (1 = free-run, 0 = step)
//   step_btn  in   async raw push-button, active-high
//   halt_req  in   synchronous halt level from the CPU
//   cpu_en    out  registered one-cycle advance strobe
//   state     out  FSM state: STOP=00, RUN=01, HALT=10
//   step_cnt  out  number of cpu_en pulses issued
module cpu_step_ctrl #(
  parameter int unsigned DIV_FAST = 4,
  parameter int unsigned DIV_SLOW = 24,
  parameter int unsigned DB_BITS  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SW2,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt_req,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic [31:0] step_cnt
);

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  // Low-N-bit masks for the divider; N=31 yields all ones.
  localparam logic [30:0] MASK_FAST = 31'({31{1'b1}} >> (31 - DIV_FAST));
  localparam logic [30:0] MASK_SLOW = 31'({31{1'b1}} >> (31 - DIV_SLOW));

  // Two-flop synchronizers: bit 0 is the metastable stage, bit 1 is safe.
  logic [1:0] sw2_sync_q, sw2_sync_d;
  logic [1:0] run_sync_q, run_sync_d;
  logic [1:0] btn_sync_q, btn_sync_d;
  logic       sw2_s, run_s, btn_s;

  logic [30:0]        div_cnt_q, div_cnt_d;
  logic [30:0]        div_mask;
  logic               tick;

  logic [DB_BITS-1:0] db_cnt_q, db_cnt_d;
  logic               btn_stable_q, btn_stable_d;
  logic               step_req_q, step_req_d;

  state_e             state_q, state_d;
  logic               cpu_en_q, cpu_en_d;

  assign sw2_s = sw2_sync_q[1];
  assign run_s = run_sync_q[1];
  assign btn_s = btn_sync_q[1];

  // Synchronizers and divider
  always_comb begin
    sw2_sync_d = {sw2_sync_q[0], SW2};
    run_sync_d = {run_sync_q[0], run_sw};
    btn_sync_d = {btn_sync_q[0], step_btn};
    div_cnt_d  = div_cnt_q + 31'd1;
    // The counter never restarts on a rate change, so a switch simply makes
    // the next tick land on the next all-ones pattern of the new width.
    div_mask   = sw2_s ? MASK_SLOW : MASK_FAST;
    tick       = ((div_cnt_q & div_mask) == div_mask);
  end

  // Debouncer: the synchronized button must disagree with btn_stable for
  // 2^DB_BITS consecutive cycles before it is accepted.
  always_comb begin
    db_cnt_d     = db_cnt_q;
    btn_stable_d = btn_stable_q;
    step_req_d   = 1'b0;
    if (btn_s == btn_stable_q) begin
      db_cnt_d = '0;
    end else if (&db_cnt_q) begin
      btn_stable_d = btn_s;
      db_cnt_d     = '0;
      step_req_d   = btn_s;  // press edges only; release is never a step
    end else begin
      db_cnt_d = db_cnt_q + DB_BITS'(1);
    end
  end

  // Mode FSM, priority-ordered per state.
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    unique case (state_q)
      ST_STOP: begin
        if (halt_req)   state_d = ST_HALT;
        else if (run_s) state_d = ST_RUN;
        else            cpu_en_d = step_req_q;
      end
      ST_RUN: begin
        // A halt in the tick cycle swallows that tick.
        if (halt_req)    state_d = ST_HALT;
        else if (!run_s) state_d = ST_STOP;
        else             cpu_en_d = tick;
      end
      ST_HALT: begin
        // Pending presses are dropped; leaving needs run_sw low.
        if (!run_s && !halt_req) state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw2_sync_q   <= '0;
      run_sync_q   <= '0;
      btn_sync_q   <= '0;
      div_cnt_q    <= '0;
      db_cnt_q     <= '0;
      btn_stable_q <= 1'b0;
      step_req_q   <= 1'b0;
    end else begin
      sw2_sync_q   <= sw2_sync_d;
      run_sync_q   <= run_sync_d;
      btn_sync_q   <= btn_sync_d;
      div_cnt_q    <= div_cnt_d;
      db_cnt_q     <= db_cnt_d;
      btn_stable_q <= btn_stable_d;
      step_req_q   <= step_req_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_STOP;
      cpu_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpu_en_q <= cpu_en_d;
    end
  end

`ifdef STEP_CNT_EN
  logic [31:0] step_cnt_q, step_cnt_d;

  // Counts on the same edge that registers cpu_en high.
  always_comb begin
    step_cnt_d = step_cnt_q + {31'd0, cpu_en_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_cnt_q <= '0;
    else     step_cnt_q <= step_cnt_d;
  end

  assign step_cnt = step_cnt_q;
`else
  assign step_cnt = 32'h0;
`endif

  assign cpu_en = cpu_en_q;
  assign state  = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DIV_FAST=2, DIV_SLOW=4, DB_BITS=3.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cpu_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        SW2 = 1'b0;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt_req = 1'b0;
  logic        cpu_en;
  logic [1:0]  state;
  logic [31:0] step_cnt;

  int          errors = 0;
  int          checks = 0;
  int          cycle = 0;
  int          npulse = 0;
  int          last_pulse = -1;
  int          exp_period = 0;
  bit          gap_en = 1'b0;
  bit          last_en = 1'b0;
  logic [31:0] exp_cnt = 32'h0;

  always #5 clk = ~clk;

  cpu_step_ctrl #(
    .DIV_FAST(2),
    .DIV_SLOW(4),
    .DB_BITS (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .SW2     (SW2),
    .run_sw  (run_sw),
    .step_btn(step_btn),
    .halt_req(halt_req),
    .cpu_en  (cpu_en),
    .state   (state),
    .step_cnt(step_cnt)
  );

  function automatic logic [31:0] exp_step();
`ifdef STEP_CNT_EN
    return exp_cnt;
`else
    return 32'h0;
`endif
  endfunction

  // Advance one cycle, sample, and update the pulse/counter model.
  task automatic cyc();
    @(negedge clk);
    cycle++;
    if (rst) begin
      exp_cnt = 32'h0;
      last_en = 1'b0;
    end else if (cpu_en === 1'b1) begin
      exp_cnt = exp_cnt + 32'd1;
      npulse++;
      checks++;
      if (last_en) begin
        errors++;
        $display("FAIL back_to_back cycle=%0d: cpu_en high 2 cycles, required 1", cycle);
      end
      if (gap_en && last_pulse >= 0) begin
        checks++;
        if (cycle - last_pulse != exp_period) begin
          errors++;
          $display("FAIL period cycle=%0d: got %0d required %0d", cycle, cycle - last_pulse, exp_period);
        end
      end
      last_pulse = cycle;
      last_en = 1'b1;
    end else begin
      last_en = 1'b0;
    end
    checks++;
    if (step_cnt !== exp_step()) begin
      errors++;
      $display("FAIL step_cnt cycle=%0d: got %h required %h", cycle, step_cnt, exp_step());
    end
  endtask

  task automatic chk_state(input logic [1:0] exp, input string name);
    checks++;
    if (state !== exp) begin
      errors++;
      $display("FAIL %s: state got %b required %b", name, state, exp);
    end
  endtask

  task automatic chk_int(input int got, input int exp, input string name);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    checks++;
    if (cpu_en !== 1'b0 || state !== 2'b00 || step_cnt !== 32'h0) begin
      errors++;
      $display("FAIL %s: got cpu_en=%b state=%b step_cnt=%h required 0/00/0", name, cpu_en, state, step_cnt);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1 chk_reset_outputs("reset_async");
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    chk_state(2'b00, "reset_release_state");
    chk_int(npulse, 0, "reset_release_pulses");
  endtask

  task automatic test_free_run();
    int p0;
    run_sw = 1'b1;
    SW2 = 1'b0;
    repeat (5) cyc();
    chk_state(2'b01, "free_run_state");
    exp_period = 4;
    gap_en = 1'b1;
    last_pulse = -1;
    p0 = npulse;
    repeat (40) cyc();
    chk_int(npulse - p0, 10, "free_run_pulse_count");
    chk_state(2'b01, "free_run_state_end");
  endtask

  task automatic test_rate_switch();
    int p0;
    SW2 = 1'b1;
    gap_en = 1'b0;
    repeat (20) cyc();
    last_pulse = -1;
    exp_period = 16;
    gap_en = 1'b1;
    p0 = npulse;
    repeat (64) cyc();
    chk_int(npulse - p0, 4, "slow_pulse_count");
    gap_en = 1'b0;
  endtask

  task automatic test_step();
    int p0, t0, first;
    run_sw = 1'b0;
    repeat (5) cyc();
    chk_state(2'b00, "step_mode_state");
    p0 = npulse;
    step_btn = 1'b1; cyc();
    step_btn = 1'b0; cyc();
    step_btn = 1'b1; cyc();
    step_btn = 1'b0;
    repeat (6) cyc();
    chk_int(npulse - p0, 0, "glitch_no_step");
    step_btn = 1'b1;
    t0 = cycle;
    first = -1;
    repeat (20) begin
      cyc();
      if (cpu_en === 1'b1 && first < 0) first = cycle - t0;
    end
    chk_int(npulse - p0, 1, "press_one_step");
    chk_int(first, 11, "press_latency");
    p0 = npulse;
    step_btn = 1'b0;
    repeat (20) cyc();
    chk_int(npulse - p0, 0, "release_no_step");
  endtask

  task automatic test_halt();
    int  p0;
    bit  found;
    SW2 = 1'b0;
    run_sw = 1'b1;
    repeat (6) cyc();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (cpu_en === 1'b1) found = 1'b1;
    end
    chk_int(int'(found), 1, "halt_find_pulse");
    // Next tick occupies the third cycle after this pulse sample.
    repeat (3) cyc();
    halt_req = 1'b1;
    p0 = npulse;
    cyc();
    checks++;
    if (cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL halt_suppress: cpu_en got %b required 0", cpu_en);
    end
    chk_state(2'b10, "halt_state");
    step_btn = 1'b1;
    repeat (15) cyc();
    step_btn = 1'b0;
    repeat (15) cyc();
    chk_int(npulse - p0, 0, "halt_ignores_step");
    chk_state(2'b10, "halt_hold");
    run_sw = 1'b0;
    halt_req = 1'b0;
    repeat (3) cyc();
    chk_state(2'b00, "halt_exit");
    repeat (5) cyc();
    chk_int(npulse - p0, 0, "halt_press_lost");
  endtask

  task automatic test_wrap();
    int p0;
`ifdef STEP_CNT_EN
    force dut.step_cnt_q = 32'hFFFF_FFFE;
    exp_cnt = 32'hFFFF_FFFE;
    #1 release dut.step_cnt_q;
    checks++;
    if (step_cnt !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL wrap_preload: got %h required fffffffe", step_cnt);
    end
`endif
    run_sw = 1'b1;
    SW2 = 1'b0;
    p0 = npulse;
    for (int i = 0; i < 30 && (npulse - p0) < 2; i++) cyc();
    chk_int(npulse - p0, 2, "wrap_two_pulses");
    checks++;
    if (step_cnt !== 32'h0) begin
      errors++;
      $display("FAIL wrap_value: got %h required 00000000", step_cnt);
    end
    run_sw = 1'b0;
    repeat (5) cyc();
  endtask

  task automatic test_reset_debounce();
    int p0, t0, first;
    chk_state(2'b00, "rdb_start_state");
    step_btn = 1'b1;
    repeat (6) cyc();
    p0 = npulse;
    rst = 1'b1;
    #1 chk_reset_outputs("rdb_async");
    repeat (2) cyc();
    rst = 1'b0;
    t0 = cycle;
    first = -1;
    repeat (20) begin
      cyc();
      if (cpu_en === 1'b1 && first < 0) first = cycle - t0;
    end
    chk_int(first, 11, "rdb_full_debounce");
    chk_int(npulse - p0, 1, "rdb_one_step");
    step_btn = 1'b0;
    repeat (15) cyc();
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_rate_switch();
    test_step();
    test_halt();
    test_wrap();
    test_reset_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
